pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central stall/flush scheduler for the 5-stage RV32 pipeline (PC, IF, ID, EXE, MEM, WB).
- Collects stall requests from ID (load-use hazard), EXE (multi-cycle unit busy) and MEM (data-bus handshake), plus redirect requests from EXE (jump/branch taken).
- Drives one per-stage stall vector, one per-stage flush (bubble) vector and the PC redirect.
- Tracks data-bus wait time with a timeout, and keeps stall/flush performance counters.

Parameters:
ADDR_WIDTH, 32, PC / jump target width
MEM_TIMEOUT, 16, max consecutive MEM wait cycles before bus error (>=2)
CNT_WIDTH, 32, performance counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
stallreq_id_i  in  1  load-use hazard from ID; combinational, same cycle
stallreq_exe_i  in  1  EXE multi-cycle unit busy
mem_req_i  in  1  MEM stage has a data-bus access outstanding
mem_ack_i  in  1  data bus completes the access this cycle
jump_i  in  1  EXE redirect request; 1-cycle pulse
jump_addr_i  in  ADDR_WIDTH  redirect target
stall_o  out  6  per-stage hold; bit0 PC, 1 IF/ID, 2 ID/EXE, 3 EXE/MEM, 4 MEM/WB, 5 WB
flush_o  out  6  per-stage bubble; same bit map, loads NOP into that stage's register
new_pc_o  out  ADDR_WIDTH  redirect target
new_pc_valid_o  out  1  PC loads new_pc_o this edge
bus_err_o  out  1  1-cycle pulse on MEM timeout
stall_cnt_o  out  CNT_WIDTH  cycles with stall_o[0]=1; saturating
flush_cnt_o  out  CNT_WIDTH  redirects applied; saturating

Behaviour:
- Reset (rst_i=0, async):
  - state=RUN; all outputs 0; pending jump cleared; counters 0.
- Control outputs:
  - stall_o, flush_o, new_pc_* are combinational from the current inputs and registered state.
  - State, pending jump, wait counter and perf counters update on the rising clk_i edge.
- Priority, highest first:
  1. Timeout.
  2. MEM wait: mem_req_i & !mem_ack_i → stall_o=6'b011111, flush_o=6'b100000.
  3. EXE busy → stall_o=6'b001111, flush_o=6'b010000.
  4. Redirect: jump_i or pending → flush_o=6'b001110 (IF, ID, EXE bubbles), stall_o=0, new_pc_valid_o=1.
  5. Load-use → stall_o=6'b000111, flush_o=6'b001000.
  6. Otherwise all 0.
- Redirect vs load-use: a redirect overrides a simultaneous load-use stall, because the hazarding instruction is flushed.
- Jump during higher-priority stall:
  - Capture jump_addr_i into the pending register, pending=1; EXE drops jump_i after one cycle.
  - Apply the redirect in the first cycle with no MEM/EXE stall, then clear pending.
  - A new jump_i while pending is set overwrites the target; jump_i=1 with pending means a fresh pulse, and the latest target wins.
- new_pc_o = jump_addr_i when jump_i is 1, else the pending target.
- FSM:
  - RUN → MEM_WAIT when mem_req_i & !mem_ack_i; wait_cnt=1.
  - MEM_WAIT:
    - mem_ack_i → RUN; that cycle is not stalled.
    - wait_cnt==MEM_TIMEOUT-1 with no ack → TIMEOUT.
    - Otherwise wait_cnt++.
  - TIMEOUT (one cycle): bus_err_o=1, flush_o=6'b111110, stall_o=6'b000001, pending cleared; → RUN.
  - RUN → EXE_WAIT when stallreq_exe_i and no MEM wait; EXE_WAIT → RUN when stallreq_exe_i falls. MEM wait arising in EXE_WAIT → MEM_WAIT.
  - Output decode in EXE_WAIT matches the priority list; the state exists for stall accounting only.
- Simultaneous mem_req_i & mem_ack_i in RUN: no stall, stay in RUN.
- Counters:
  - stall_cnt_o increments every cycle stall_o[0]=1 (including TIMEOUT).
  - flush_cnt_o increments on each new_pc_valid_o.
  - Both saturate at all-ones.
- Reset mid-wait: all state, pending and counters clear immediately; the outstanding bus access is abandoned.

Decomposition:
- Shared defines header: stage bit indices (STG_PC..STG_WB), FSM state encodings (RUN, MEM_WAIT, EXE_WAIT, TIMEOUT), 6-bit constant vectors for stall/flush patterns.
- One sub-module: sat_counter (parameter width, inc_i, count_o; async active-low reset), instantiated twice.
- Priority decode stays inline.

Test Plan:
- Load-use: stallreq_id_i=1 for 1 cycle → stall_o=6'b000111, flush_o=6'b001000 that cycle; next cycle all 0; stall_cnt_o=1.
- MEM wait: mem_req_i=1, ack after 3 cycles → stall_o=6'b011111 and flush_o=6'b100000 for 3 cycles; no stall on the ack cycle; bus_err_o stays 0.
- Timeout with MEM_TIMEOUT=16 and no ack → bus_err_o pulses exactly 1 cycle, flush_o=6'b111110, then state RUN.
- Jump in MEM wait: jump_i pulse with target 0x0000_0100 during the wait → no redirect while stalled; on the first free cycle new_pc_valid_o=1, new_pc_o=0x100, flush_o=6'b001110; flush_cnt_o=1.
- Redirect beats load-use: jump_i and stallreq_id_i together → flush_o=6'b001110, stall_o=0.
- Async reset asserted mid MEM_WAIT with counters non-zero → all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler: stage bit
// positions, scheduler states and the fixed stall/flush patterns.
package pipe_ctrl_pkg;

  localparam int NUM_STAGES = 6;

  localparam int STG_PC    = 0;
  localparam int STG_IF_ID = 1;
  localparam int STG_ID_EX = 2;
  localparam int STG_EX_MM = 3;
  localparam int STG_MM_WB = 4;
  localparam int STG_WB    = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    EXE_WAIT = 2'd2,
    TIMEOUT  = 2'd3
  } state_e;

  // Stall holds every register upstream of the stalled stage; the flush
  // inserts a bubble into the first register downstream of it.
  localparam logic [NUM_STAGES-1:0] STALL_MEM      = 6'b011111;
  localparam logic [NUM_STAGES-1:0] FLUSH_MEM      = 6'b100000;
  localparam logic [NUM_STAGES-1:0] STALL_EXE      = 6'b001111;
  localparam logic [NUM_STAGES-1:0] FLUSH_EXE      = 6'b010000;
  localparam logic [NUM_STAGES-1:0] FLUSH_REDIRECT = 6'b001110;
  localparam logic [NUM_STAGES-1:0] STALL_LOADUSE  = 6'b000111;
  localparam logic [NUM_STAGES-1:0] FLUSH_LOADUSE  = 6'b001000;
  localparam logic [NUM_STAGES-1:0] STALL_TIMEOUT  = 6'b000001;
  localparam logic [NUM_STAGES-1:0] FLUSH_TIMEOUT  = 6'b111110;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline hazard requests and the scheduler's stall/flush/redirect
// responses. The scheduler is the slave; the pipeline stages are the master.
interface pipe_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  stallreq_id_i;
  logic                  stallreq_exe_i;
  logic                  mem_req_i;
  logic                  mem_ack_i;
  logic                  jump_i;
  logic [ADDR_WIDTH-1:0] jump_addr_i;

  logic [5:0]            stall_o;
  logic [5:0]            flush_o;
  logic [ADDR_WIDTH-1:0] new_pc_o;
  logic                  new_pc_valid_o;
  logic                  bus_err_o;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;
  logic [CNT_WIDTH-1:0]  flush_cnt_o;

  modport slave (
    input  stallreq_id_i, stallreq_exe_i, mem_req_i, mem_ack_i, jump_i, jump_addr_i,
    output stall_o, flush_o, new_pc_o, new_pc_valid_o, bus_err_o, stall_cnt_o, flush_cnt_o
  );

  modport master (
    output stallreq_id_i, stallreq_exe_i, mem_req_i, mem_ack_i, jump_i, jump_addr_i,
    input  stall_o, flush_o, new_pc_o, new_pc_valid_o, bus_err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: prioritises hazard
// requests, defers redirects that arrive while stalled, and times out the data bus.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  pipe_ctrl_if.slave  bus
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [WCW-1:0]        wait_q, wait_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

  logic                  mem_wait;
  logic                  redirect;
  logic [5:0]            stall;
  logic [5:0]            flush;
  logic                  pc_valid;
  logic                  bus_err;

  always_comb begin
    mem_wait = bus.mem_req_i & ~bus.mem_ack_i;
    redirect = bus.jump_i | pend_q;
    stall    = '0;
    flush    = '0;
    pc_valid = 1'b0;
    bus_err  = 1'b0;
    if (state_q == TIMEOUT) begin
      bus_err = 1'b1;
      stall   = STALL_TIMEOUT;
      flush   = FLUSH_TIMEOUT;
    end else if (mem_wait) begin
      stall = STALL_MEM;
      flush = FLUSH_MEM;
    end else if (bus.stallreq_exe_i) begin
      stall = STALL_EXE;
      flush = FLUSH_EXE;
    end else if (redirect) begin
      // The redirect also squashes any load-use hazard in ID.
      flush    = FLUSH_REDIRECT;
      pc_valid = 1'b1;
    end else if (bus.stallreq_id_i) begin
      stall = STALL_LOADUSE;
      flush = FLUSH_LOADUSE;
    end
  end

  // A jump seen while stalled is parked here until the first free cycle.
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (state_q == TIMEOUT) begin
      pend_d = 1'b0;
    end else if (pc_valid) begin
      pend_d = 1'b0;
    end else if (bus.jump_i) begin
      pend_d      = 1'b1;
      pend_addr_d = bus.jump_addr_i;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN, EXE_WAIT: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
          wait_d  = WCW'(1);
        end else if (bus.stallreq_exe_i) begin
          state_d = EXE_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          if (wait_q == WCW'(MEM_TIMEOUT - 1)) begin
            state_d = TIMEOUT;
          end else begin
            wait_d = wait_q + WCW'(1);
          end
        end else begin
          state_d = bus.stallreq_exe_i ? EXE_WAIT : RUN;
          wait_d  = '0;
        end
      end
      TIMEOUT: begin
        state_d = RUN;
        wait_d  = '0;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      wait_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Outputs are forced low while reset is held, even if requests stay asserted.
  assign bus.stall_o        = rst_i ? stall : '0;
  assign bus.flush_o        = rst_i ? flush : '0;
  assign bus.new_pc_valid_o = rst_i & pc_valid;
  assign bus.bus_err_o      = rst_i & bus_err;
  assign bus.new_pc_o       = !rst_i ? '0 : (bus.jump_i ? bus.jump_addr_i : pend_addr_q);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall[STG_PC]),
    .count_o (bus.stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (pc_valid),
    .count_o (bus.flush_cnt_o)
  );

endmodule
